// File: rtl/max_pkg.sv
// Shared defaults and the result record for the max-finder datapath and its consumers.
package max_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_CNT_W  = 8;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] max;
    logic [DEF_CNT_W-1:0]  idx;
    logic [DEF_CNT_W-1:0]  cnt;
  } result_t;

endpackage

// File: rtl/max_sat_counter.sv
// Saturating up-counter with restart; sat is sticky until the next clr.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  localparam logic [W-1:0] MAX_Q = '1;

  // clr together with inc counts the restarting sample itself, so q becomes 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      q   <= W'(inc);
      sat <= 1'b0;
    end else if (inc) begin
      if (q == MAX_Q) sat <= 1'b1;
      else            q   <= q + 1'b1;
    end
  end

endmodule

// File: rtl/max_datapath.sv
// Running-maximum datapath for the max-finder FSM: compare flag, max/index tracking,
// per-run sample count and a result record captured when the FSM signals done.
module max_datapath
  import max_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ldMax,
  input  logic              done,
  output logic              in_GTR_Max,
  output logic [DATA_W-1:0] max_val,
  output logic [DATA_W-1:0] res_max,
  output logic [CNT_W-1:0]  res_idx,
  output logic [CNT_W-1:0]  res_cnt,
  output logic              res_valid,
  output logic              cnt_sat
);

  typedef struct packed {
    logic [DATA_W-1:0] max;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  cnt;
  } res_t;

  logic              r_start_d;
  logic              r_done_d;
  logic [DATA_W-1:0] r_max;
  logic [CNT_W-1:0]  r_max_idx;
  res_t              r_res;
  logic              r_res_valid;

  logic              w_first;
  logic              w_capture;
  logic [CNT_W-1:0]  w_sample_cnt;
  logic [CNT_W-1:0]  w_cur_idx;

  assign w_first    = start & ~r_start_d;
  assign w_capture  = done & ~r_done_d;
  assign w_cur_idx  = w_first ? '0 : w_sample_cnt;
  assign in_GTR_Max = (data_in > r_max);

  sat_counter #(.W(CNT_W)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (w_first),
    .inc (start),
    .q   (w_sample_cnt),
    .sat (cnt_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start_d <= 1'b0;
      r_done_d  <= 1'b0;
    end else begin
      r_start_d <= start;
      r_done_d  <= done;
    end
  end

  // A load outside a run would corrupt the max of the next capture, so start gates it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_max     <= '0;
      r_max_idx <= '0;
    end else if (ldMax && start) begin
      r_max     <= data_in;
      r_max_idx <= w_cur_idx;
    end
  end

  // Only the rising edge of done captures; an FSM parked in done must not re-fire.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res       <= '0;
      r_res_valid <= 1'b0;
    end else begin
      r_res_valid <= w_capture;
      if (w_capture) begin
        r_res.max <= r_max;
        r_res.idx <= r_max_idx;
        r_res.cnt <= w_sample_cnt;
      end
    end
  end

  assign max_val   = r_max;
  assign res_max   = r_res.max;
  assign res_idx   = r_res.idx;
  assign res_cnt   = r_res.cnt;
  assign res_valid = r_res_valid;

endmodule

// File: tb/tb_max_datapath.sv
// Randomized scoreboard bench: an 8-bit-count and a 3-bit-count instance share one stimulus.
module tb_max_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ldMax = 1'b0;
  logic       done = 1'b0;
  logic [7:0] data_in = 8'd0;

  logic       a_gtr, a_res_valid, a_cnt_sat;
  logic [7:0] a_max_val, a_res_max, a_res_idx, a_res_cnt;
  logic       b_gtr, b_res_valid, b_cnt_sat;
  logic [7:0] b_max_val, b_res_max;
  logic [2:0] b_res_idx, b_res_cnt;

  typedef struct {
    int mx;
    int idx;
    int cnt;
    int sat;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   m_maxreg = 0;

  max_datapath #(.DATA_W(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ldMax(ldMax), .done(done),
    .in_GTR_Max(a_gtr), .max_val(a_max_val), .res_max(a_res_max), .res_idx(a_res_idx),
    .res_cnt(a_res_cnt), .res_valid(a_res_valid), .cnt_sat(a_cnt_sat)
  );

  max_datapath #(.DATA_W(8), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in), .ldMax(ldMax), .done(done),
    .in_GTR_Max(b_gtr), .max_val(b_max_val), .res_max(b_res_max), .res_idx(b_res_idx),
    .res_cnt(b_res_cnt), .res_valid(b_res_valid), .cnt_sat(b_cnt_sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
  endtask

  // Result of a run: largest sample, first position of it, sample count, clipped at cmax.
  function automatic exp_t ref_result(input int s[$], input int cmax);
    exp_t e;
    int best = 0;
    int at = 0;
    for (int i = 0; i < s.size(); i++)
      if (i == 0 || s[i] > best) begin
        best = s[i];
        at = i;
      end
    e.mx  = best;
    e.idx = (at > cmax) ? cmax : at;
    e.cnt = (s.size() > cmax) ? cmax : s.size();
    e.sat = (s.size() > cmax) ? 1 : 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (a_res_valid) begin
      if (qa.size() == 0) chk("a_spurious_res_valid", 1, 0);
      else begin
        e = qa.pop_front();
        chk("a_res_max", a_res_max, e.mx);
        chk("a_res_idx", a_res_idx, e.idx);
        chk("a_res_cnt", a_res_cnt, e.cnt);
        chk("a_cnt_sat", a_cnt_sat, e.sat);
      end
    end
    if (b_res_valid) begin
      if (qb.size() == 0) chk("b_spurious_res_valid", 1, 0);
      else begin
        e = qb.pop_front();
        chk("b_res_max", b_res_max, e.mx);
        chk("b_res_idx", b_res_idx, e.idx);
        chk("b_res_cnt", b_res_cnt, e.cnt);
        chk("b_cnt_sat", b_cnt_sat, e.sat);
      end
    end
  end

  // Acts as the FSM: ldMax forced on the first sample, otherwise on a new strict maximum.
  task automatic run_samples(input int s[$]);
    for (int i = 0; i < s.size(); i++) begin
      bit gt;
      @(posedge clk); #1;
      gt = (s[i] > m_maxreg);
      start = 1'b1;
      data_in = 8'(s[i]);
      ldMax = (i == 0) || gt;
      if (i > 0) done = 1'b0;
      @(negedge clk);
      chk("a_in_GTR_Max", a_gtr, gt);
      chk("b_in_GTR_Max", b_gtr, gt);
      chk("a_max_val", a_max_val, m_maxreg);
      chk("b_max_val", b_max_val, m_maxreg);
      if (ldMax) m_maxreg = s[i];
    end
  endtask

  task automatic end_run(input int s[$], input bit keep);
    if (done) begin
      @(posedge clk); #1;
      start = 1'b0; ldMax = 1'b0; done = 1'b0;
    end
    qa.push_back(ref_result(s, 255));
    qb.push_back(ref_result(s, 7));
    @(posedge clk); #1;
    start = 1'b0;
    done = 1'b1;
    ldMax = 1'($urandom_range(0, 1));
    data_in = 8'($urandom);
    @(posedge clk); #1;
    ldMax = 1'b0;
    if (!keep) done = 1'b0;
    chk("a_max_hold_idle", a_max_val, m_maxreg);
    chk("b_max_hold_idle", b_max_val, m_maxreg);
  endtask

  task automatic do_run(input int s[$], input bit keep);
    run_samples(s);
    end_run(s, keep);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_max_val"}, a_max_val, 0);
    chk({tag, "_a_res_max"}, a_res_max, 0);
    chk({tag, "_a_res_idx"}, a_res_idx, 0);
    chk({tag, "_a_res_cnt"}, a_res_cnt, 0);
    chk({tag, "_a_res_valid"}, a_res_valid, 0);
    chk({tag, "_a_cnt_sat"}, a_cnt_sat, 0);
    chk({tag, "_b_max_val"}, b_max_val, 0);
    chk({tag, "_b_res_cnt"}, b_res_cnt, 0);
    chk({tag, "_b_cnt_sat"}, b_cnt_sat, 0);
    data_in = 8'd5;
    #1;
    chk({tag, "_a_gtr_5"}, a_gtr, 1);
    chk({tag, "_b_gtr_5"}, b_gtr, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int s[$];
    int wait_cyc;

    #3;
    check_all_zero("reset");
    #8 rst = 1'b0;

    s = '{3, 9, 4, 9, 7};   do_run(s, 1'b0);
    s = '{200, 10};         do_run(s, 1'b0);
    s = '{1, 2};            do_run(s, 1'b0);
    s = '{0};               do_run(s, 1'b0);
    s.delete();
    for (int i = 1; i <= 10; i++) s.push_back(i);
    do_run(s, 1'b1);
    s = '{5, 5, 1};         do_run(s, 1'b0);
    s = '{0, 0, 0};         do_run(s, 1'b0);
    s = '{77};              do_run(s, 1'b1);
    s = '{12, 30};          do_run(s, 1'b0);

    s = '{8, 20, 6};
    run_samples(s);
    @(posedge clk); #1;
    start = 1'b1; data_in = 8'd50; ldMax = 1'b0;
    #2 rst = 1'b1;
    #1;
    start = 1'b0; ldMax = 1'b0; done = 1'b0;
    check_all_zero("abort");
    m_maxreg = 0;
    @(posedge clk); #2;
    rst = 1'b0;
    s = '{4};               do_run(s, 1'b0);

    for (int r = 0; r < 40; r++) begin
      int n;
      int mode;
      bit keep;
      s.delete();
      n = $urandom_range(1, 20);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < n; i++)
        s.push_back((mode == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255));
      keep = 1'($urandom_range(0, 1));
      do_run(s, keep);
      if (!keep) repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    @(posedge clk); #1;
    done = 1'b0; start = 1'b0;
    wait_cyc = 0;
    while ((qa.size() != 0 || qb.size() != 0) && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    @(negedge clk);
    chk("a_results_outstanding", qa.size(), 0);
    chk("b_results_outstanding", qb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/max_datapath.md
Name: max_datapath

Overview:
- Datapath companion to the max-finder control FSM. It holds the running maximum register, drives the `in_GTR_Max` compare flag to the FSM, and loads on the FSM's `ldMax`.
- It also counts samples in each run, tracks the index of the maximum, and captures a result record (max, index, count) when the FSM raises `done`.
- Sits between the sample source and the FSM; its results go to downstream consumers.

Parameters:
- DATA_W, 8, width of each sample and of the max register.
- CNT_W, 8, width of the sample counter and of the index fields.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  run-enable, shared with the FSM. One sample is consumed per cycle while high.
- data_in  in  DATA_W  sample presented this cycle (unsigned).
- ldMax  in  1  from FSM: load data_in into the max register at the next edge.
- done  in  1  from FSM: run finished, capture results.
- in_GTR_Max  out  1  to FSM: combinational, data_in > max_reg.
- max_val  out  DATA_W  live running maximum (registered).
- res_max  out  DATA_W  captured maximum of the last completed run.
- res_idx  out  CNT_W  0-based index of the first occurrence of res_max.
- res_cnt  out  CNT_W  number of samples in the last run.
- res_valid  out  1  one-cycle pulse when the res_* outputs update.
- cnt_sat  out  1  sticky: the sample counter saturated during the current or last run.

Behaviour:
- Reset (asynchronous, immediate):
  - max_reg, max_idx, sample_cnt, res_max, res_idx, res_cnt are all 0.
  - res_valid = 0, cnt_sat = 0, start_d = 0.
  - in_GTR_Max then follows data_in > 0.
- Comparator:
  - in_GTR_Max = (data_in > max_reg), unsigned, purely combinational, zero latency.
  - Equality gives 0, so the first occurrence of a maximum wins.
- Run boundary:
  - start_d is start registered by one cycle.
  - first = start & ~start_d.
- Sample counter (sample_cnt):
  - On first: sample_cnt <= 1, cnt_sat <= 0.
  - Else if start: sample_cnt <= sample_cnt + 1, saturating at 2^CNT_W-1. When the increment would overflow, hold the value and set cnt_sat.
  - Else: hold.
- Index of the current sample:
  - cur_idx = first ? 0 : sample_cnt.
- Max load:
  - When ldMax is high at an edge: max_reg <= data_in, max_idx <= cur_idx.
  - The FSM forces ldMax on the first sample of a run, so stale max_reg values from the previous run are overwritten.
  - ldMax while start is low is ignored; max_reg holds.
- Result capture:
  - When done is high at an edge: res_max <= max_reg, res_idx <= max_idx, res_cnt <= sample_cnt, res_valid <= 1.
  - res_valid is an edge-detected pulse: it fires only on the first cycle of a done assertion. The FSM may hold done high while idle; that does not re-fire res_valid.
  - Capture uses register values from before the edge. A simultaneous ldMax is ignored because start is low when done is high.
- Boundary cases:
  - A start pulse of one cycle gives a run with res_cnt = 1 and res_idx = 0.
  - If start rises in the same cycle done is still high, capture happens first, then the new run starts.
  - rst mid-run clears everything; no res_valid is produced for the aborted run.
  - An all-zero stream gives res_max = 0 and res_idx = 0.
  - Saturation: max_idx can never exceed 2^CNT_W-1. Later samples during saturation report index 2^CNT_W-1.
- Latency:
  - Compare: 0 cycles.
  - Max update: 1 cycle.
  - Result: res_valid 1 cycle after the first edge on which done is sampled high.

Decomposition:
- Package max_pkg:
  - DEF_DATA_W = 8, DEF_CNT_W = 8.
  - Typedef result_t as a packed struct {max, idx, cnt}.
- Sub-module sat_counter (parameter W; ports clr, inc, q, sat).
- Top-level max_system (FSM plus this block) is a separate file.

Test Plan:
- Reset/idle: assert rst mid-cycle -> all outputs 0 immediately; in_GTR_Max = 1 for data_in = 5.
- Basic run: start high for 5 cycles with data 3,9,4,9,7, then low -> res_valid pulse; res_max = 9, res_idx = 1, res_cnt = 5; ldMax seen on samples 0 and 1 only.
- Back-to-back runs: run {200,10}, then run {1,2} -> second result res_max = 2, res_idx = 1, res_cnt = 2; the stale 200 does not persist.
- Single sample: one-cycle start with data 0 -> res_max = 0, res_idx = 0, res_cnt = 1.
- Saturation (CNT_W = 3): 10 samples, with the largest at index 9 -> res_cnt = 7, cnt_sat = 1, res_idx = 7.
- Abort: rst during sample 3 of a run -> no res_valid; the next run of {4} reports res_max = 4, res_cnt = 1.
